// File: rtl/pe_pkg.sv
// Shared defaults and FSM state type for the PE partial-sum datapath.
package pe_pkg;

  localparam int DEF_PROD_WIDTH = 10;
  localparam int DEF_ACC_WIDTH  = 16;
  localparam int DEF_FILTER_LEN = 5;

  typedef enum logic [0:0] {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } psum_state_e;

endpackage

// File: rtl/psum_sat_add.sv
// Combinational partial-sum adder: acc + zero-extended prod.
// PSUM_SAT_EN defined: clamp to all-ones on overflow and flag it; undefined: wrap, ovf=0.
module psum_sat_add
  import pe_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic [ACC_WIDTH-1:0]  sum,
  output logic                  ovf
);

`ifdef PSUM_SAT_EN
  localparam int EXT_W = ACC_WIDTH + 1;

  logic [EXT_W-1:0] ext_s;

  // Add with one guard bit; the carry-out selects the clamp value.
  always_comb begin
    ext_s = {1'b0, acc} + EXT_W'(prod);
    ovf   = ext_s[ACC_WIDTH];
    if (ext_s[ACC_WIDTH]) begin
      sum = {ACC_WIDTH{1'b1}};
    end else begin
      sum = ext_s[ACC_WIDTH-1:0];
    end
  end
`else
  // Modulo-2^ACC_WIDTH addition; overflow is never reported.
  always_comb begin
    sum = acc + ACC_WIDTH'(prod);
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/psum_accumulator.sv
// Windowed partial-sum accumulator: sums FILTER_LEN products, then holds the sum for a handshake.
// Optional PSUM_SAT_EN selects saturating arithmetic with a sticky per-window sat_flag.
module psum_accumulator
  import pe_pkg::*;
#(
  parameter int PROD_WIDTH = DEF_PROD_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  sat_flag
);

  localparam int CNT_W = $clog2(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  psum_state_e          state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic                 sat_r;
  logic                 prod_ready_r;
  logic                 out_valid_r;
  logic [ACC_WIDTH-1:0] sum_s;
  logic                 ovf_s;

  psum_sat_add #(
    .PROD_WIDTH(PROD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .acc (acc_r),
    .prod(prod_data),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // Window FSM with handshake outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ACCUM;
      cnt_r        <= {CNT_W{1'b0}};
      acc_r        <= {ACC_WIDTH{1'b0}};
      sat_r        <= 1'b0;
      prod_ready_r <= 1'b1;
      out_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (prod_valid) begin
            // The first product of a window restarts the sum and clears the sticky flag.
            if (cnt_r == {CNT_W{1'b0}}) begin
              acc_r <= ACC_WIDTH'(prod_data);
              sat_r <= 1'b0;
            end else begin
              acc_r <= sum_s;
              sat_r <= sat_r | ovf_s;
            end
            if (cnt_r == CNT_LAST) begin
              cnt_r        <= {CNT_W{1'b0}};
              state_r      <= OUTPUT;
              prod_ready_r <= 1'b0;
              out_valid_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_r      <= ACCUM;
            prod_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= ACCUM;
          cnt_r        <= {CNT_W{1'b0}};
          acc_r        <= {ACC_WIDTH{1'b0}};
          sat_r        <= 1'b0;
          prod_ready_r <= 1'b1;
          out_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = prod_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = acc_r;
  assign sat_flag   = sat_r;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table, directed corner sequences,
// and randomized traffic against a window-sum reference model (both PSUM_SAT_EN builds).
module tb_psum_accumulator;

  localparam int PW   = 10;
  localparam int AW   = 16;
  localparam int FL   = 5;
  localparam int AW12 = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            prod_valid, prod_ready, out_valid, out_ready, sat_flag;
  logic [PW-1:0]   prod_data;
  logic [AW-1:0]   out_data;
  logic            p12_valid, p12_ready, o12_valid, o12_ready, s12_flag;
  logic [PW-1:0]   p12_data;
  logic [AW12-1:0] o12_data;

  always #5 clk = ~clk;

  psum_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod_data(prod_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag)
  );

  psum_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW12), .FILTER_LEN(FL)) dut12 (
    .clk(clk), .rst(rst), .prod_valid(p12_valid), .prod_ready(p12_ready),
    .prod_data(p12_data), .out_valid(o12_valid), .out_ready(o12_ready),
    .out_data(o12_data), .sat_flag(s12_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: products accepted in the current window, and the pending result.
  int m_q[$];
  bit m_pend;
  int m_exp;
  bit m_sat;
  int got_q[$];
  int n_busy;

  function automatic void window_sum(input int w, output int s, output bit sat);
    longint lim;
    longint t;
    lim = longint'(1) << w;
    s   = 0;
    sat = 1'b0;
    foreach (m_q[i]) begin
      t = longint'(s) + longint'(m_q[i]);
      if (t >= lim) begin
`ifdef PSUM_SAT_EN
        t   = lim - 1;
        sat = 1'b1;
`else
        t   = t - lim;
`endif
      end
      s = int'(t);
    end
  endfunction

  task automatic cycle(input bit pv, input int pd, input bit ordy);
    prod_valid = pv;
    prod_data  = PW'(pd);
    out_ready  = ordy;
    if (out_valid === 1'b1 && ordy) got_q.push_back(int'(out_data));
    @(posedge clk); #1;
    if (m_pend) begin
      if (ordy) m_pend = 1'b0;
    end else if (pv) begin
      m_q.push_back(pd);
      if (m_q.size() == FL) begin
        window_sum(AW, m_exp, m_sat);
        m_pend = 1'b1;
        m_q.delete();
      end
    end
    if (prod_ready === 1'b0) n_busy++;
    chk("prod_ready", prod_ready, !m_pend);
    chk("out_valid", out_valid, m_pend);
    if (m_pend) begin
      chk("out_data", out_data, m_exp);
      chk("sat_flag", sat_flag, m_sat);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    prod_valid = 1'b0; prod_data = '0; out_ready = 1'b0;
    p12_valid = 1'b0; p12_data = '0; o12_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_pend = 1'b0;
  endtask

  typedef struct {
    bit pv;
    int pd;
    bit ordy;
    bit e_rdy;
    bit e_vld;
    int e_dat;
  } vec_t;

  vec_t tbl[16];
  int   exp_sum;
  int   pd_r;
  int   exp12;
  bit   sat12;

  initial begin
    // Back-to-back window with immediate drain, then a window held for three cycles.
    tbl[0]  = '{1, 1, 1, 1, 0, -1};
    tbl[1]  = '{1, 2, 1, 1, 0, -1};
    tbl[2]  = '{1, 3, 1, 1, 0, -1};
    tbl[3]  = '{1, 4, 1, 1, 0, -1};
    tbl[4]  = '{1, 5, 1, 0, 1, 15};
    tbl[5]  = '{0, 0, 1, 1, 0, -1};
    tbl[6]  = '{1, 1, 0, 1, 0, -1};
    tbl[7]  = '{1, 2, 0, 1, 0, -1};
    tbl[8]  = '{1, 3, 0, 1, 0, -1};
    tbl[9]  = '{1, 4, 0, 1, 0, -1};
    tbl[10] = '{1, 5, 0, 0, 1, 15};
    tbl[11] = '{1, 9, 0, 0, 1, 15};
    tbl[12] = '{1, 9, 0, 0, 1, 15};
    tbl[13] = '{1, 9, 0, 0, 1, 15};
    tbl[14] = '{1, 9, 1, 1, 0, 15};
    tbl[15] = '{0, 0, 1, 1, 0, 15};

    rst = 1'b1;
    n_busy = 0;
    do_reset(2);
    chk("reset prod_ready", prod_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 0);
    chk("reset sat_flag", sat_flag, 1'b0);
    chk("reset12 prod_ready", p12_ready, 1'b1);
    chk("reset12 out_valid", o12_valid, 1'b0);

    for (int i = 0; i < 16; i++) begin
      prod_valid = tbl[i].pv;
      prod_data  = PW'(tbl[i].pd);
      out_ready  = tbl[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("tbl[%0d] prod_ready", i), prod_ready, tbl[i].e_rdy);
      chk($sformatf("tbl[%0d] out_valid", i), out_valid, tbl[i].e_vld);
      if (tbl[i].e_dat >= 0) chk($sformatf("tbl[%0d] out_data", i), out_data, tbl[i].e_dat);
    end

    // Reset mid-window (with a product offered on the reset edge) discards the 7+7 sum.
    do_reset(1);
    got_q.delete();
    cycle(1, 7, 1);
    cycle(1, 7, 1);
    prod_valid = 1'b1; prod_data = PW'(7); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q.delete(); m_pend = 1'b0;
    chk("midrst prod_ready", prod_ready, 1'b1);
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst out_data", out_data, 0);
    for (int i = 0; i < FL; i++) cycle(1, 1, 1);
    cycle(0, 0, 1);
    chk("midrst emissions", got_q.size(), 1);
    if (got_q.size() >= 1) chk("midrst sum", got_q[0], 5);

    // Two windows with prod_valid held high: one bubble per window.
    got_q.delete();
    n_busy = 0;
    for (int i = 1; i <= 5; i++) cycle(1, i, 1);
    repeat (7) cycle(1, 10, 1);
    prod_valid = 1'b0;
    chk("b2b emissions", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("b2b first", got_q[0], 15);
      chk("b2b second", got_q[1], 50);
    end
    chk("b2b bubbles", n_busy, 2);

    // prod_valid toggling with junk data on idle cycles.
    got_q.delete();
    exp_sum = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      pd_r = int'($urandom_range(0, 1023));
      if (i % 2 == 0) exp_sum += pd_r;
      cycle(i % 2 == 0, pd_r, 1);
    end
    chk("toggle emissions", got_q.size(), 1);
    if (got_q.size() >= 1) chk("toggle sum", got_q[0], exp_sum);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)), $urandom_range(0, 1) == 1);
    end
    cycle(0, 0, 1);

    // 12-bit accumulator: five products of 1023 overflow.
`ifdef PSUM_SAT_EN
    exp12 = 4095; sat12 = 1'b1;
`else
    exp12 = 1019; sat12 = 1'b0;
`endif
    p12_valid = 1'b1; p12_data = PW'(1023); o12_ready = 1'b0;
    repeat (FL) @(posedge clk);
    #1;
    p12_valid = 1'b0;
    chk("acc12 out_valid", o12_valid, 1'b1);
    chk("acc12 out_data", o12_data, exp12);
    chk("acc12 sat_flag", s12_flag, sat12);
    o12_ready = 1'b1;
    @(posedge clk); #1;
    o12_ready = 1'b0;
    chk("acc12 drained", o12_valid, 1'b0);
    chk("acc12 sat sticky", s12_flag, sat12);
    p12_valid = 1'b1; p12_data = PW'(1);
    @(posedge clk); #1;
    p12_valid = 1'b0;
    chk("acc12 sat cleared", s12_flag, 1'b0);
    chk("acc12 new window", o12_data, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 10, the multiplier product width.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, the partial-sum width.
REQ-003 SHALL have parameter FILTER_LEN, default 5, the number of products per window (legal range 2..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port prod_valid, input, 1 bit: a product is offered.
REQ-007 SHALL have port prod_ready, output, 1 bit: a product can be accepted.
REQ-008 SHALL have port prod_data, input, PROD_WIDTH bits: unsigned product from the multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: a window sum is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the sum.
REQ-011 SHALL have port out_data, output, ACC_WIDTH bits: the window partial sum.
REQ-012 SHALL have port sat_flag, output, 1 bit: saturation occurred within the current output window.

Function
REQ-013 SHALL implement a two-state FSM.
- ACCUM: prod_ready=1, out_valid=0.
- OUTPUT: prod_ready=0, out_valid=1.
REQ-014 SHALL define a product transfer as prod_valid&&prod_ready at a rising edge, and an output transfer as out_valid&&out_ready at a rising edge.
REQ-015 SHALL, on a product transfer with cnt==0, load acc with zero-extended prod_data.
REQ-016 SHALL, on a product transfer with cnt>0, load acc with acc+prod_data under the arithmetic rule of REQ-025/REQ-026.
REQ-017 SHALL increment cnt on each product transfer while cnt<FILTER_LEN-1.
REQ-018 SHALL, on the transfer with cnt==FILTER_LEN-1, set cnt=0 and move to OUTPUT, so out_valid rises the cycle after the last product.
REQ-019 SHALL hold out_data and sat_flag stable in OUTPUT until the output transfer, regardless of prod_valid.
REQ-020 SHALL, on the output transfer, return to ACCUM; the earliest next product transfer is the following edge (one bubble cycle per window).
REQ-021 SHALL drive out_data=acc at all times; it is meaningful only while out_valid=1.
REQ-022 SHALL ignore prod_data while prod_valid=0, and SHALL never stall with prod_valid held low mid-window (partial state is retained).

Reset
REQ-023 SHALL, while rst=1 at an edge, set state=ACCUM, cnt=0, acc=0 and sat_flag=0, so that out_valid=0 and prod_ready=1 from the next cycle.
REQ-024 SHALL, on reset mid-window or during OUTPUT, discard any partial or pending sum without emitting it; rst has priority over every transfer in the same cycle.

Configuration
REQ-025 SHALL, with PSUM_SAT_EN defined, clamp an addition that overflows to 2^ACC_WIDTH-1 and set sat_flag, which stays set until the next window's first product transfer.
REQ-026 SHALL, with PSUM_SAT_EN undefined, wrap additions modulo 2^ACC_WIDTH and tie sat_flag to 0.

Structure
REQ-027 SHALL place the following in shared package pe_pkg:
- the default widths PROD_WIDTH=10, ACC_WIDTH=16 and FILTER_LEN=5;
- the FSM state enum (ACCUM, OUTPUT).
REQ-028 SHALL contain one sub-module, psum_sat_add: a combinational adder producing sum and overflow, with saturation selected by PSUM_SAT_EN.

Verification
REQ-029 SHALL check: default params, products 1,2,3,4,5 back-to-back, out_ready=1 -> out_data=15, out_valid for 1 cycle, rising the cycle after the 5th transfer.
REQ-030 SHALL check: same window with out_ready=0 for 3 cycles -> out_data=15 held, prod_ready=0 throughout, transfer on the 4th cycle.
REQ-031 SHALL check: ACC_WIDTH=12, five products of 1023 -> 4095 with sat_flag=1 (PSUM_SAT_EN), or 1019 with sat_flag=0 (undefined).
REQ-032 SHALL check: products 7,7 then rst for 1 cycle, then five products of 1 -> out_data=5 and no emission of 14.
REQ-033 SHALL check: two windows (1..5, then 10 x5) with prod_valid always high -> outputs 15 then 50, exactly one prod_ready=0 bubble between windows.
REQ-034 SHALL check: prod_valid toggled every other cycle during a window -> out_data equals the sum of accepted products only.
